// File: rtl/pipeline_nbit_adder.sv
// rtl/pipeline_nbit_adder.sv - STAGES-deep carry-pipelined adder/subtractor with valid/ready flow control.
// Optional signed-overflow output ovf is enabled by defining PIPE_ADDER_OVERFLOW_EN.
module pipeline_nbit_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             enable,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int S    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic                             advance;
  logic [WIDTH-1:0]                 b_eff;
  logic                             c_first;
  logic [S:0]                       res;

  // Per-stage registers: operands travel whole so upper slices stay available downstream.
  logic [STAGES-1:0][WIDTH-1:0]     a_q, b_q, s_q;
  logic [STAGES-1:0]                c_q, v_q;

  logic [STAGES-1:0][WIDTH-1:0]     a_src, b_src, s_src, s_d;
  logic [STAGES-1:0]                c_src, v_src, c_d;
  logic                             unused_bits;

  // Subtract is folded into the operand at acceptance, so sub never travels down the pipe.
  assign b_eff   = sub ? ~b : b;
  assign c_first = sub | cin;

  generate
    if (STAGES == 1) begin : g_single
      assign a_src = a;
      assign b_src = b_eff;
      assign s_src = '0;
      assign c_src = c_first;
      assign v_src = in_valid;
    end else begin : g_multi
      assign a_src = {a_q[STAGES-2:0], a};
      assign b_src = {b_q[STAGES-2:0], b_eff};
      assign s_src = {s_q[STAGES-2:0], {WIDTH{1'b0}}};
      assign c_src = {c_q[STAGES-2:0], c_first};
      assign v_src = {v_q[STAGES-2:0], in_valid};
    end
  endgenerate

  always_comb begin
    s_d = s_src;
    c_d = '0;
    res = '0;
    for (int k = 0; k < STAGES; k++) begin
      res = {1'b0, a_src[k][k*S +: S]} + {1'b0, b_src[k][k*S +: S]} + {{S{1'b0}}, c_src[k]};
      s_d[k][k*S +: S] = res[S-1:0];
      c_d[k]           = res[S];
    end
  end

  assign out_valid = v_q[LAST];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];

  always_ff @(posedge enable or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      v_q <= '0;
    end else if (advance) begin
      a_q <= a_src;
      b_q <= b_src;
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_src;
    end
  end

  // The last stage's operand copy is never read; it exists only to keep the arrays uniform.
  assign unused_bits = ^{a_q[LAST], b_q[LAST]};

`ifdef PIPE_ADDER_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  // Like-signed operands producing an opposite-signed result is a signed overflow.
  assign ovf_d = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
                 (s_d[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);

  always_ff @(posedge enable or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipeline_nbit_adder.sv
// tb/tb_pipeline_nbit_adder.sv - scoreboard bench for pipeline_nbit_adder (WIDTH=16, STAGES=4).
module tb_pipeline_nbit_adder;

  logic        enable;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef PIPE_ADDER_OVERFLOW_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] e;
  logic [15:0] cap_s;
  logic        cap_c;
  logic        seen;

  logic [15:0] v_a   [13] = '{16'hFFFF, 16'h0005, 16'h0007, 16'h1234, 16'h00FF, 16'h0FFF, 16'h8000,
                              16'h0000, 16'h0000, 16'hABCD, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] v_b   [13] = '{16'h0001, 16'h0007, 16'h0005, 16'h4321, 16'h0001, 16'h0000, 16'h8000,
                              16'h0000, 16'h0001, 16'h1111, 16'hFFFF, 16'h0001, 16'h0001};
  logic        v_cin [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        v_sub [13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] v_sum [13] = '{16'h0000, 16'hFFFE, 16'h0002, 16'h5556, 16'h0100, 16'h1000, 16'h0000,
                              16'h0000, 16'hFFFF, 16'hBCDE, 16'hFFFF, 16'h8000, 16'h7FFF};
  logic        v_co  [13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        v_ovf [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  pipeline_nbit_adder #(.WIDTH(16), .STAGES(4)) dut (
    .enable    (enable),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADDER_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial enable = 1'b0;
  always #5 enable = ~enable;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int i);
    logic ok;
    ok       = 1'b0;
    a        = v_a[i];
    b        = v_b[i];
    cin      = v_cin[i];
    sub      = v_sub[i];
    in_valid = 1'b1;
    for (int w = 0; w < 100; w++) begin
      @(negedge enable);
      if (in_ready) begin
        exp_q.push_back({v_ovf[i], v_co[i], v_sum[i]});
        ok = 1'b1;
        break;
      end
      @(posedge enable);
      #1;
    end
    check("accept_timeout", ok, 1'b1);
    @(posedge enable);
    #1;
    in_valid = 1'b0;
    sub      = ~sub;
    a        = 16'hDEAD;
  endtask

  task automatic latency_check();
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(posedge enable);
      @(negedge enable);
      check("latency_out_valid", out_valid, (i == 4));
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 60 && exp_q.size() > 0; w++) @(posedge enable);
    #1;
  endtask

  always @(negedge enable) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got sum %h cout %b, expected none", sum, cout);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e[15:0]);
        check("cout", cout, e[16]);
`ifdef PIPE_ADDER_OVERFLOW_EN
        check("ovf", ovf, e[17]);
`endif
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge enable);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge enable);
    #1;
    rst = 1'b1;
    @(posedge enable);
    #1;

    send(0);
    latency_check();
    @(posedge enable);
    #1;

    for (int i = 1; i < 13; i++) send(i);
    drain();

    fork
      begin
        for (int i = 3; i < 9; i++) send(i);
      end
      begin
        seen = 1'b0;
        for (int w = 0; w < 50; w++) begin
          @(posedge enable);
          #1;
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("stall_saw_valid", seen, 1'b1);
        out_ready = 1'b0;
        cap_s     = sum;
        cap_c     = cout;
        repeat (3) begin
          @(negedge enable);
          check("stall_in_ready", in_ready, 1'b0);
          check("stall_out_valid", out_valid, 1'b1);
          check("stall_sum", sum, cap_s);
          check("stall_cout", cout, cap_c);
          @(posedge enable);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_all_delivered", exp_q.size(), 0);

    out_ready = 1'b0;
    send(9);
    send(10);
    send(11);
    @(posedge enable);
    @(posedge enable);
    #2;
    check("prereset_out_valid", out_valid, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_sum", sum, 16'h0000);
    check("async_rst_cout", cout, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    @(posedge enable);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge enable);
      check("post_reset_no_valid", out_valid, 1'b0);
    end
    @(posedge enable);
    #1;
    send(2);
    latency_check();
    @(posedge enable);
    #1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
